// File: rtl/seg7_capture_if.sv
// seg7_capture_if: bundles the seven-segment capture signals.
// master drives the raw display lines and err_clr; slave is the capture block.
interface seg7_capture_if;
  logic [6:0] seg_in;
  logic       dig_sel;
  logic       err_clr;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       valid;
  logic       upd;
  logic       err;

  modport master (
    output seg_in, dig_sel, err_clr,
    input  bcd_ones, bcd_tens, valid, upd, err
  );

  modport slave (
    input  seg_in, dig_sel, err_clr,
    output bcd_ones, bcd_tens, valid, upd, err
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: samples an asynchronous seven-segment display bus, waits for
// a pattern to hold STABLE_CYCLES synchronized cycles, then decodes it into
// the ones or tens BCD digit selected by dig_sel.
// Optional feature macro SEG7_CAP_BLANK_EN: when defined, the all-off pattern
// 0x00 is a legal "blank" digit committed as 4'hF; otherwise it is an error.
module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_rst_sync;
  logic [6:0] r_seg_s1, r_seg_s2;
  logic       r_dig_s1, r_dig_s2;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_cand, w_cand_nxt;   // pair being qualified: {dig_sel, seg_in}
  logic [7:0] r_last;               // last committed pair
  logic [3:0] r_ones, r_tens;
  logic       r_ones_seen, r_tens_seen;
  logic       r_valid, r_upd, r_err;
  logic       w_commit;
  logic [7:0] w_sample;
  logic [4:0] w_dec;
  logic       w_ok;
  logic [3:0] w_digit;
  logic       w_wr_ones, w_wr_tens;

  // Returns {legal, digit}; legal=0 for any pattern outside the table.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h67:   decode = {1'b1, 4'd9};
      7'h6F:   decode = {1'b1, 4'd9};
`ifdef SEG7_CAP_BLANK_EN
      7'h00:   decode = {1'b1, 4'hF};
`else
      7'h00:   decode = {1'b0, 4'h0};
`endif
      default: decode = {1'b0, 4'h0};
    endcase
  endfunction

  assign w_sample  = {r_dig_s2, r_seg_s2};
  assign w_dec     = decode(r_cand[6:0]);
  assign w_ok      = w_dec[4];
  assign w_digit   = w_dec[3:0];
  assign w_wr_ones = w_commit & w_ok & ~r_cand[7];
  assign w_wr_tens = w_commit & w_ok &  r_cand[7];

  // Reset release is brought into the clock domain before the FSM may leave WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // Two-flop synchronizer on the asynchronous display lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= 7'h00;
      r_seg_s2 <= 7'h00;
      r_dig_s1 <= 1'b0;
      r_dig_s2 <= 1'b0;
    end else begin
      r_seg_s1 <= bus.seg_in;
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= bus.dig_sel;
      r_dig_s2 <= r_dig_s1;
    end
  end

  // FSM state, stability counter and candidate pair registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT;
      r_cnt   <= 8'd0;
      r_cand  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Next-state logic: any sample change restarts qualification at count 1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_commit    = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (r_rst_sync[1] && (w_sample != r_last)) begin
          w_cand_nxt  = w_sample;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = (STABLE_N == 8'd1) ? ST_COMMIT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_sample != r_cand) begin
          w_cand_nxt  = w_sample;
          w_cnt_nxt   = 8'd1;
          w_state_nxt = (STABLE_N == 8'd1) ? ST_COMMIT : ST_SETTLE;
        end else begin
          w_cnt_nxt = 8'(r_cnt + 8'd1);
          if (8'(r_cnt + 8'd1) == STABLE_N) w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_WAIT;
    endcase
  end

  // Commit: write the selected digit, flag changes, track validity and errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last      <= 8'h00;
      r_ones      <= 4'd0;
      r_tens      <= 4'd0;
      r_ones_seen <= 1'b0;
      r_tens_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_upd       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_commit) r_last <= r_cand;
      if (w_wr_ones) begin
        r_ones      <= w_digit;
        r_ones_seen <= 1'b1;
        r_upd       <= (w_digit != r_ones);
      end
      if (w_wr_tens) begin
        r_tens      <= w_digit;
        r_tens_seen <= 1'b1;
        r_upd       <= (w_digit != r_tens);
      end
      r_valid <= r_valid | ((r_ones_seen | w_wr_ones) & (r_tens_seen | w_wr_tens));
      if (w_commit && !w_ok) r_err <= 1'b1;
      else if (bus.err_clr)  r_err <= 1'b0;
    end
  end

  assign bus.bcd_ones = r_ones;
  assign bus.bcd_tens = r_tens;
  assign bus.valid    = r_valid;
  assign bus.upd      = r_upd;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed test of seg7_capture with STABLE_CYCLES=4.
// Inputs change 1 ns after a rising edge; the next rising edge is the first
// synchronizer sample ("edge 1"), so a held pattern is visible after edge 7.
module tb_seg7_capture;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seg7_capture_if bus_if();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus_if.seg_in  = 7'h00;
    bus_if.dig_sel = 1'b0;
    bus_if.err_clr = 1'b0;

    // Reset state
    edges(2);
    chk("rst_ones",  32'(bus_if.bcd_ones), 32'h0);
    chk("rst_tens",  32'(bus_if.bcd_tens), 32'h0);
    chk("rst_valid", 32'(bus_if.valid),    32'h0);
    chk("rst_upd",   32'(bus_if.upd),      32'h0);
    chk("rst_err",   32'(bus_if.err),      32'h0);
    rst_n = 1'b1;
    edges(4);
    chk("idle_ones", 32'(bus_if.bcd_ones), 32'h0);
    chk("idle_err",  32'(bus_if.err),      32'h0);

    // 0x5B held: visible exactly after edge 7
    bus_if.seg_in = 7'h5B;
    edges(6);
    chk("lat_before_ones", 32'(bus_if.bcd_ones), 32'h0);
    chk("lat_before_upd",  32'(bus_if.upd),      32'h0);
    edges(1);
    chk("lat_ones2", 32'(bus_if.bcd_ones), 32'h2);
    chk("lat_upd",   32'(bus_if.upd),      32'h1);
    edges(1);
    chk("lat_upd_drop", 32'(bus_if.upd),   32'h0);
    chk("lat_valid",    32'(bus_if.valid), 32'h0);

    // 0x4F glitch for 2 cycles then 0x66: 3 never committed
    bus_if.seg_in = 7'h4F;
    edges(2);
    bus_if.seg_in = 7'h66;
    edges(6);
    chk("glitch_no3",  32'(bus_if.bcd_ones), 32'h2);
    chk("glitch_noupd", 32'(bus_if.upd),     32'h0);
    edges(1);
    chk("glitch_ones4", 32'(bus_if.bcd_ones), 32'h4);
    chk("glitch_upd",   32'(bus_if.upd),      32'h1);
    edges(1);
    chk("glitch_upd_once", 32'(bus_if.upd), 32'h0);

    // Ones 5 then tens 1 -> valid
    bus_if.seg_in = 7'h6D;
    edges(7);
    chk("ones5",     32'(bus_if.bcd_ones), 32'h5);
    chk("ones5_upd", 32'(bus_if.upd),      32'h1);
    edges(1);
    bus_if.dig_sel = 1'b1;
    bus_if.seg_in  = 7'h06;
    edges(6);
    chk("tens_pre_valid", 32'(bus_if.valid), 32'h0);
    edges(1);
    chk("tens1",       32'(bus_if.bcd_tens), 32'h1);
    chk("tens1_ones",  32'(bus_if.bcd_ones), 32'h5);
    chk("tens1_upd",   32'(bus_if.upd),      32'h1);
    chk("tens1_valid", 32'(bus_if.valid),    32'h1);
    edges(1);

    // Same pattern recommitted to the other digit holding the same value
    bus_if.dig_sel = 1'b0;
    edges(7);
    chk("ones1",     32'(bus_if.bcd_ones), 32'h1);
    chk("ones1_upd", 32'(bus_if.upd),      32'h1);
    edges(1);
    bus_if.dig_sel = 1'b1;
    edges(7);
    chk("same_noupd", 32'(bus_if.upd),      32'h0);
    chk("same_tens",  32'(bus_if.bcd_tens), 32'h1);
    chk("same_ones",  32'(bus_if.bcd_ones), 32'h1);
    edges(1);
    chk("same_noupd2", 32'(bus_if.upd), 32'h0);

    // Invalid 0x49 sets err; err_clr clears it
    bus_if.dig_sel = 1'b0;
    bus_if.seg_in  = 7'h49;
    edges(7);
    chk("bad_err",   32'(bus_if.err),      32'h1);
    chk("bad_ones",  32'(bus_if.bcd_ones), 32'h1);
    chk("bad_tens",  32'(bus_if.bcd_tens), 32'h1);
    chk("bad_noupd", 32'(bus_if.upd),      32'h0);
    bus_if.err_clr = 1'b1;
    edges(1);
    bus_if.err_clr = 1'b0;
    chk("clr_err", 32'(bus_if.err), 32'h0);

    // err_clr coincident with an error commit keeps err set
    bus_if.seg_in = 7'h3F;
    edges(8);
    chk("ones0", 32'(bus_if.bcd_ones), 32'h0);
    bus_if.seg_in = 7'h49;
    edges(6);
    chk("coinc_pre_err", 32'(bus_if.err), 32'h0);
    bus_if.err_clr = 1'b1;
    edges(1);
    bus_if.err_clr = 1'b0;
    chk("coinc_err", 32'(bus_if.err), 32'h1);
    bus_if.err_clr = 1'b1;
    edges(1);
    bus_if.err_clr = 1'b0;
    chk("clr_err2", 32'(bus_if.err), 32'h0);

    // All-off pattern 0x00
    bus_if.seg_in = 7'h00;
    edges(7);
`ifdef SEG7_CAP_BLANK_EN
    chk("blank_ones", 32'(bus_if.bcd_ones), 32'hF);
    chk("blank_err",  32'(bus_if.err),      32'h0);
    chk("blank_upd",  32'(bus_if.upd),      32'h1);
`else
    chk("blank_ones", 32'(bus_if.bcd_ones), 32'h0);
    chk("blank_err",  32'(bus_if.err),      32'h1);
    chk("blank_upd",  32'(bus_if.upd),      32'h0);
`endif
    edges(1);

    // Reset mid-SETTLE of 0x7F, then full requalification
    bus_if.seg_in = 7'h7F;
    edges(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ones",  32'(bus_if.bcd_ones), 32'h0);
    chk("mid_rst_tens",  32'(bus_if.bcd_tens), 32'h0);
    chk("mid_rst_valid", 32'(bus_if.valid),    32'h0);
    chk("mid_rst_err",   32'(bus_if.err),      32'h0);
    chk("mid_rst_upd",   32'(bus_if.upd),      32'h0);
    edges(2);
    rst_n = 1'b1;
    edges(6);
    chk("requal_pre", 32'(bus_if.bcd_ones), 32'h0);
    edges(1);
    chk("requal_ones8", 32'(bus_if.bcd_ones), 32'h8);
    chk("requal_upd",   32'(bus_if.upd),      32'h1);
    chk("requal_valid", 32'(bus_if.valid),    32'h0);
    chk("requal_err",   32'(bus_if.err),      32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive synchronized cycles a pattern must hold before commit; legal range 1..255.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 seg_in  input  7  active-high segments, bit0=a .. bit6=g; asynchronous to clk.
REQ-005 dig_sel  input  1  0 = seg_in shows ones digit, 1 = tens digit; asynchronous.
REQ-006 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-007 bcd_ones  output  4  last committed ones digit.
REQ-008 bcd_tens  output  4  last committed tens digit.
REQ-009 valid  output  1  high once both digits have been committed since reset.
REQ-010 upd  output  1  one-cycle pulse when a commit changes bcd_ones or bcd_tens.
REQ-011 err  output  1  sticky flag, set when an undecodable pattern is committed.

Function
REQ-012 seg_in and dig_sel SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Decode table SHALL be 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, both 0x67 and 0x6F=9; every other pattern is invalid.
REQ-014 FSM states: WAIT (held pattern already committed), SETTLE (counting stability), COMMIT (one cycle, writes outputs).
REQ-015 WAIT -> SETTLE when the synchronized {dig_sel, seg_in} differs from the last committed pair; stability counter loads 1.
REQ-016 In SETTLE, unchanged sample increments counter; any change in seg_in or dig_sel reloads counter to 1 and stays in SETTLE.
REQ-017 SETTLE -> COMMIT when counter reaches STABLE_CYCLES; COMMIT -> WAIT unconditionally.
REQ-018 Latency: a change first sampled at synchronizer edge 1 SHALL be visible on outputs after edge 2+STABLE_CYCLES+1, if held steady.
REQ-019 COMMIT with valid pattern SHALL write the decoded digit to bcd_tens if dig_sel=1, else bcd_ones; the other digit is unchanged.
REQ-020 upd SHALL pulse in the cycle after COMMIT only if the written digit value differs from its previous value.
REQ-021 COMMIT with invalid pattern SHALL set err, leave both digits unchanged, and not pulse upd.
REQ-022 valid SHALL rise after the first valid commits to both ones and tens and stay high until reset.
REQ-023 err_clr clears err next edge; err_clr coincident with an error-setting COMMIT leaves err=1.
REQ-024 Re-commit of an identical valid digit (same pattern after a dig_sel toggle) SHALL update nothing visible and not pulse upd.

Reset
REQ-025 rst_n low SHALL asynchronously force FSM=WAIT, counter=0, synchronizers=0, bcd_ones=0, bcd_tens=0, valid=0, upd=0, err=0, last committed pair = {0, 0x00}.
REQ-026 Reset asserted mid-SETTLE SHALL discard the pending pattern; after release the pattern is re-qualified from scratch.
REQ-027 Reset release SHALL be synchronized to clk before FSM leaves WAIT.

Configuration
REQ-028 Macro SEG7_CAP_BLANK_EN defined: pattern 0x00 is legal and commits digit value 4'hF (blank), with no err and upd per REQ-020.
REQ-029 Macro SEG7_CAP_BLANK_EN undefined: 0x00 is invalid and sets err per REQ-021.

Verification
REQ-030 STABLE_CYCLES=4, dig_sel=0, seg_in 0x00->0x5B held -> bcd_ones=2, upd one pulse, outputs change exactly 7 edges after first sample.
REQ-031 seg_in=0x4F held 2 cycles then 0x66 held -> no commit of 3; bcd_ones=4 after full qualification, single upd.
REQ-032 Ones 0x6D then dig_sel=1 with 0x06 -> bcd_ones=5, bcd_tens=1, valid=1, two upd pulses.
REQ-033 seg_in=0x49 held -> err=1, digits unchanged, no upd; err_clr pulse -> err=0; err_clr coincident with new 0x49 commit -> err stays 1.
REQ-034 seg_in=0x00 held with macro defined -> bcd_ones=4'hF, err=0; without macro -> err=1, bcd_ones unchanged.
REQ-035 rst_n low 2 cycles into SETTLE of 0x7F -> all outputs 0 immediately; after release held 0x7F commits bcd_ones=8 after full latency.
